fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch sequencer.
// It requests a word at pc_current, waits for the response, and presents it
// to the datapath until the datapath acknowledges it with the next PC.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, an
// acknowledged pc_next with nonzero low bits traps into a sticky FAULT state.
// When it is undefined, pc_next is forced to word alignment instead.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_REQ  | imem_req high at pc_current, waiting for imem_ready
// ST_WAIT | request accepted, waiting for imem_rvalid
// ST_HOLD | instruction presented (instr_valid), waiting for instr_ack
// ST_FAULT| misaligned PC was acknowledged; idle until reset
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          ICOUNT_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         pc_next,
  input  logic                instr_ack,
  output logic                imem_req,
  output logic [63:0]         imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic                instr_valid,
  output logic [31:0]         instruction_current,
  output logic [63:0]         pc_current,
  output logic [ICOUNT_W-1:0] instr_count,
  output logic                fetch_fault
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [63:0]          r_pc;
  logic [31:0]          r_instr;
  logic [ICOUNT_W-1:0]  r_count;
  logic                 w_ack;
  logic                 w_capture;
  logic                 w_misaligned;
  logic [63:0]          w_pc_load;

`ifdef FETCH_ALIGN_CHECK_EN
  logic                 r_fault;

  assign w_misaligned = (pc_next[1:0] != 2'b00);
  assign w_pc_load    = pc_next;
  assign fetch_fault  = r_fault;

  // Sticky fault flag, set when a misaligned PC is acknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_ack && w_misaligned) begin
      r_fault <= 1'b1;
    end
  end
`else
  logic                 w_unused_pc_lsb;

  // Low PC bits are dropped, so a misaligned target can never reach FAULT.
  assign w_unused_pc_lsb = ^pc_next[1:0];
  assign w_misaligned    = 1'b0;
  assign w_pc_load       = {pc_next[63:2], 2'b00};
  assign fetch_fault     = 1'b0;
`endif

  // Only the state that owns the event may act on it; everything else ignores it.
  assign w_ack     = (r_state == ST_HOLD) && instr_ack;
  assign w_capture = (r_state == ST_WAIT) && imem_rvalid;

  assign imem_addr           = r_pc;
  assign pc_current          = r_pc;
  assign instruction_current = r_instr;
  assign instr_count         = r_count;

  // State register; reset discards any outstanding fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
          w_state_nxt = w_misaligned ? ST_FAULT : ST_REQ;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  // PC, instruction word and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_count <= '0;
    end else begin
      if (w_capture) begin
        r_instr <= imem_rdata;
      end
      if (w_ack) begin
        r_pc    <= w_pc_load;
        r_count <= r_count + ICOUNT_W'(1);
      end
    end
  end

endmodule
